// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial receiver and its serializer bench:
// FSM state encoding and the idle level of the scl/sda lines.
package sipo_rx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_DATA      = 2'd1;
    localparam state_t ST_STOP_WAIT = 2'd2;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sipo_rx_edge.sv
// Two-flop synchronizer plus previous-sample stage for scl/sda, decoding start, stop and bit strobe.
// Events are combinational off the registered samples: visible 2 sclk edges after a pin change.
module sipo_rx_edge
    import sipo_rx_pkg::*;
(
    input  logic sclk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic start,
    output logic stop,
    output logic bit_strobe,
    output logic sda_now
);

    // [0] first sync flop, [1] synchronized "now" sample, [2] "prev" sample
    logic [2:0] scl_sh;
    logic [2:0] sda_sh;
    logic       scl_now;
    logic       scl_prev;
    logic       sda_prev;

    always_ff @(posedge sclk) begin
        if (!rst) begin
            scl_sh <= {3{LINE_IDLE}};
            sda_sh <= {3{LINE_IDLE}};
        end else begin
            scl_sh <= {scl_sh[1:0], scl};
            sda_sh <= {sda_sh[1:0], sda};
        end
    end

    assign scl_now  = scl_sh[1];
    assign scl_prev = scl_sh[2];
    assign sda_now  = sda_sh[1];
    assign sda_prev = sda_sh[2];

    assign start      =  sda_prev & ~sda_now & scl_now;
    assign stop       = ~sda_prev &  sda_now & scl_now;
    assign bit_strobe = ~scl_prev &  scl_now;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out frame receiver: start, NBITS LSB-first bits, stop-bit low phase, stop.
// d_valid pulses 3 sclk edges after the stop reaches the pins; no backpressure, frames are never held.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int NBITS   = 4,
    parameter int TIMEOUT = 64
)
(
    input  logic             sclk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda,
    output logic [NBITS-1:0] data,
    output logic             d_valid,
    output logic             frm_err,
    output logic             busy
);

    localparam int CW = $clog2(NBITS + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    logic             start;
    logic             stop;
    logic             bit_strobe;
    logic             sda_now;
    state_t           state;
    logic [NBITS-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [TW-1:0]    to_cnt;

    sipo_rx_edge u_edge (
        .sclk       (sclk),
        .rst        (rst),
        .scl        (scl),
        .sda        (sda),
        .start      (start),
        .stop       (stop),
        .bit_strobe (bit_strobe),
        .sda_now    (sda_now)
    );

    always_ff @(posedge sclk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
            data    <= '0;
            d_valid <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            d_valid <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (start) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (start) begin
                        frm_err <= 1'b1;
                        shreg   <= '0;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end else if (stop) begin
                        frm_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (bit_strobe) begin
                        shreg   <= {sda_now, shreg[NBITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        to_cnt  <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP_WAIT;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        frm_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_STOP_WAIT: begin
                    // the strobe here is the stop-bit low phase: it only refreshes the timeout
                    if (stop) begin
                        data    <= shreg;
                        d_valid <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (start) begin
                        frm_err <= 1'b1;
                        shreg   <= '0;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                        state   <= ST_DATA;
                    end else if (bit_strobe) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        frm_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: a behavioural serializer drives scl/sda, outcomes are checked per frame.
module tb_sipo_rx;
    import sipo_rx_pkg::*;

    localparam int NBITS   = 4;
    localparam int TIMEOUT = 64;

    logic             sclk = 1'b0;
    logic             rst  = 1'b0;
    logic             scl  = LINE_IDLE;
    logic             sda  = LINE_IDLE;
    logic [NBITS-1:0] data;
    logic             d_valid;
    logic             frm_err;
    logic             busy;

    sipo_rx #(.NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
        .sclk    (sclk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sda),
        .data    (data),
        .d_valid (d_valid),
        .frm_err (frm_err),
        .busy    (busy)
    );

    always #5 sclk = ~sclk;

    int nvec     = 0;
    int nmis     = 0;
    int dv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;

    // cycles high, so a stretched pulse shows up as a count above one
    always @(posedge sclk) begin
        #1;
        if (d_valid === 1'b1) dv_cnt++;
        if (frm_err === 1'b1) fe_cnt++;
        if (d_valid === 1'b1 && frm_err === 1'b1) both_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic idle(input int n);
        scl = LINE_IDLE;
        sda = LINE_IDLE;
        step(n);
    endtask

    task automatic send_start();
        sda = 1'b0;
        step(1);
    endtask

    task automatic send_bit(input logic b);
        scl = 1'b0;
        sda = b;
        step(1);
        scl = 1'b1;
        step(1);
    endtask

    task automatic send_stop();
        scl = 1'b0;
        sda = 1'b0;
        step(1);
        scl = 1'b1;
        step(1);
        sda = 1'b1;
        step(1);
    endtask

    task automatic send_full(input logic [NBITS-1:0] p);
        send_start();
        for (int i = 0; i < NBITS; i++) send_bit(p[i]);
        send_stop();
        idle(6);
    endtask

    // last data bit forced low so sda can rise with scl high: a stop after n bits
    task automatic send_trunc(input logic [NBITS-1:0] p, input int n);
        send_start();
        for (int i = 0; i < n; i++) send_bit((i == n - 1) ? 1'b0 : p[i]);
        sda = 1'b1;
        step(1);
        idle(6);
    endtask

    task automatic run_frame(input string name, input logic [NBITS-1:0] p, input int n,
                             input bit full, input int exp_dv, input int exp_fe,
                             input logic [NBITS-1:0] exp_data);
        int dv0, fe0;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        if (full) send_full(p);
        else      send_trunc(p, n);
        check({name, " d_valid"}, dv_cnt - dv0, exp_dv);
        check({name, " frm_err"}, fe_cnt - fe0, exp_fe);
        check({name, " data"}, 32'(data), 32'(exp_data));
        check({name, " busy"}, 32'(busy), 0);
    endtask

    typedef struct {
        logic [NBITS-1:0] payload;
        int               nbits;
        bit               full;
        int               exp_dv;
        int               exp_fe;
        logic [NBITS-1:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int               dv0, fe0, k;
        logic             busy_at;
        logic [NBITS-1:0] pat;
        logic [NBITS-1:0] model_data;

        vecs[0] = '{4'hA, 4, 1'b1, 1, 0, 4'hA};
        vecs[1] = '{4'h3, 4, 1'b1, 1, 0, 4'h3};
        vecs[2] = '{4'hC, 4, 1'b1, 1, 0, 4'hC};
        vecs[3] = '{4'h1, 2, 1'b0, 0, 1, 4'hC};
        vecs[4] = '{4'hF, 4, 1'b1, 1, 0, 4'hF};
        vecs[5] = '{4'h0, 0, 1'b0, 0, 1, 4'hF};
        vecs[6] = '{4'h7, 3, 1'b0, 0, 1, 4'hF};
        vecs[7] = '{4'h0, 4, 1'b1, 1, 0, 4'h0};
        vecs[8] = '{4'h9, 1, 1'b0, 0, 1, 4'h0};

        rst = 1'b0;
        step(3);
        check("reset data", 32'(data), 0);
        check("reset d_valid", 32'(d_valid), 0);
        check("reset frm_err", 32'(frm_err), 0);
        check("reset busy", 32'(busy), 0);
        rst = 1'b1;
        idle(4);

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].payload, vecs[i].nbits, vecs[i].full,
                      vecs[i].exp_dv, vecs[i].exp_fe, vecs[i].exp_data);
        end

        // stop latency from the pins to d_valid
        dv0 = dv_cnt;
        pat = 4'h6;
        send_start();
        for (int i = 0; i < NBITS; i++) send_bit(pat[i]);
        scl = 1'b0;
        sda = 1'b0;
        step(1);
        scl = 1'b1;
        step(1);
        sda = 1'b1;
        k = -1;
        for (int j = 1; j <= 10; j++) begin
            @(posedge sclk);
            #1;
            if (d_valid === 1'b1 && k < 0) k = j;
        end
        step(1);
        idle(4);
        check("stop latency", k, 3);
        check("latency data", 32'(data), 32'h6);
        check("latency d_valid", dv_cnt - dv0, 1);

        // new start after 2 bits restarts reception
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_start();
        pat = 4'h5;
        for (int i = 0; i < NBITS; i++) send_bit(pat[i]);
        send_stop();
        idle(6);
        check("restart frm_err", fe_cnt - fe0, 1);
        check("restart d_valid", dv_cnt - dv0, 1);
        check("restart data", 32'(data), 32'h5);

        // scl stuck high after one bit; the strobe registers on the 3rd edge after the pin rises
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_start();
        scl = 1'b0;
        sda = 1'b1;
        step(1);
        scl = 1'b1;
        k = -1;
        busy_at = 1'bx;
        for (int j = 1; j <= 120; j++) begin
            @(posedge sclk);
            #1;
            if (frm_err === 1'b1 && k < 0) begin
                k = j;
                busy_at = busy;
            end
        end
        step(1);
        idle(2);
        check("timeout edge", k, TIMEOUT + 3);
        check("timeout busy", 32'(busy_at), 0);
        check("timeout frm_err", fe_cnt - fe0, 1);
        check("timeout d_valid", dv_cnt - dv0, 0);
        check("timeout data", 32'(data), 32'h5);

        // reset pulse during bit 2 drops the frame silently
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_start();
        send_bit(1'b0);
        scl = 1'b0;
        sda = 1'b1;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check("midrst data", 32'(data), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst d_valid", 32'(d_valid), 0);
        check("midrst frm_err", 32'(frm_err), 0);
        step(2);
        scl = 1'b1;
        step(1);
        idle(4);
        check("midrst no pulse", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
        check("midrst still idle", 32'(busy), 0);
        run_frame("after reset", 4'h9, NBITS, 1'b1, 1, 0, 4'h9);

        // random frames against an outcome-level model
        model_data = 4'h9;
        for (int i = 0; i < 24; i++) begin
            bit full;
            int n;
            pat  = NBITS'($urandom_range(0, (1 << NBITS) - 1));
            full = ($urandom_range(0, 2) != 0);
            n    = full ? NBITS : int'($urandom_range(0, NBITS - 1));
            if (full) model_data = pat;
            run_frame($sformatf("rnd%0d", i), pat, n, full, full ? 1 : 0, full ? 0 : 1, model_data);
        end

        check("dv and fe overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter NBITS, default 4, payload bits per frame.
REQ-002 Parameter TIMEOUT, default 64, max sclk cycles between scl rising edges inside a frame.
REQ-003 Reset rst, synchronous, active-low; clock sclk.
REQ-004 sclk  input  1  sampling clock, same clock that drives the upstream serializer.
REQ-005 rst  input  1  synchronous reset, active-low.
REQ-006 scl  input  1  serial bit clock from upstream serializer.
REQ-007 sda  input  1  serial data line, idle high.
REQ-008 data  output  NBITS  last received payload, bit 0 received first.
REQ-009 d_valid  output  1  one-cycle pulse: data updated with a good frame.
REQ-010 frm_err  output  1  one-cycle pulse: frame aborted.
REQ-011 busy  output  1  high while a frame is in progress (any state except IDLE).

Function
REQ-012 scl and sda SHALL pass through a 2-flop synchronizer on posedge sclk; a third register holds the previous synchronized sample (prev/now).
REQ-013 Start condition SHALL be sda prev=1, now=0 with scl now=1; stop condition SHALL be sda prev=0, now=1 with scl now=1; bit strobe SHALL be scl prev=0, now=1.
REQ-014 Bit sampling SHALL work at 2 sclk samples per scl period, i.e. scl toggling every sclk cycle.
REQ-015 FSM states: IDLE, DATA, STOP_WAIT.
REQ-016 IDLE: on start, clear shift register and bit counter, go to DATA; all other events are ignored.
REQ-017 DATA: on each bit strobe, shift sda now into the shift register LSB-first and increment the counter; after the NBITS-th bit, go to STOP_WAIT.
REQ-018 STOP_WAIT: bit strobes are ignored (the stop-bit low phase); on a stop condition, load data from the shift register, pulse d_valid, and go to IDLE.
REQ-019 d_valid SHALL assert on the sclk edge after the stop condition is detected: 3 sclk cycles after the stop is first present at the pins.
REQ-020 A stop condition in DATA (fewer than NBITS bits) SHALL pulse frm_err, leave data unchanged, and go to IDLE.
REQ-021 A start condition in DATA or STOP_WAIT SHALL pulse frm_err and restart reception: counter cleared, state DATA.
REQ-022 Timeout counter: cleared on every bit strobe and on entry to DATA; counts while busy; when it reaches TIMEOUT-1, pulse frm_err and go to IDLE.
REQ-023 d_valid and frm_err SHALL never be high in the same cycle; d_valid takes priority only if both events coincide.
REQ-024 data SHALL hold its value until the next good frame.
REQ-025 Bit counter width SHALL be clog2(NBITS+1); timeout counter width SHALL be clog2(TIMEOUT).

Reset
REQ-026 rst low at posedge sclk SHALL force: state IDLE, data=0, d_valid=0, frm_err=0, busy=0, counters=0, synchronizer stages=1 (idle line).
REQ-027 Reset mid-frame SHALL discard the partial frame with no frm_err pulse.
REQ-028 After reset release, a frame SHALL be accepted only after a fresh start condition.

Structure
REQ-029 The state encoding and line idle level SHALL live in a shared package also used by the serializer bench.
REQ-030 The synchronizer plus prev-sample and edge/condition decode SHALL be one sub-module, sipo_rx_edge, outputting start, stop, bit_strobe and sda_now.

Verification
REQ-031 Serializer sends 4'hA -> data=4'hA, one d_valid pulse, frm_err=0, busy low afterwards.
REQ-032 Back-to-back frames 4'h3 then 4'hC -> two d_valid pulses, data 4'h3 then 4'hC, no error.
REQ-033 Start, 2 bits, then stop -> frm_err one cycle, data keeps its previous value, state IDLE.
REQ-034 Start, 1 bit, scl held high -> frm_err exactly TIMEOUT=64 cycles after the last strobe, busy drops.
REQ-035 Start, 2 bits, new start, then full frame 4'h5 -> one frm_err, then d_valid with data=4'h5.
REQ-036 rst low for 1 cycle during bit 2 -> outputs zeroed, no pulses; the next full frame 4'h9 is received correctly.
